// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB stage: state encoding, RV32I load/store
// funct3 codes, and the legality/alignment rules used to gate memory requests.
package pipe_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    if (is_store) ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
    else          ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    return ok;
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane handling for the data-memory port: store strobes and lane
// replication, plus load byte/half extraction with sign or zero extension.
module load_store_align
  import pipe_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_strb_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_strb_o  = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_strb_o  = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_strb_o  = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = ld_rdata_i[7:0];
    case (ld_off_i)
      2'd1:    byte_sel = ld_rdata_i[15:8];
      2'd2:    byte_sel = ld_rdata_i[23:16];
      2'd3:    byte_sel = ld_rdata_i[31:24];
      default: byte_sel = ld_rdata_i[7:0];
    endcase
    half_sel = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
  end

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      LB:      ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      ld_data_o = {{16{half_sel[15]}}, half_sel};
      LBU:     ld_data_o = {24'd0, byte_sel};
      LHU:     ld_data_o = {16'd0, half_sel};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// MEM stage plus MEM/WB register: issues one data-memory transaction per
// load/store, stalls upstream while it waits, and abandons it after WAIT_LIMIT.
module mem_wb
  import pipe_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out,
  input  logic [31:0] src2_st1,
  input  logic [4:0]  rd_addr_mem,
  input  logic        wb_en_mem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_addr_wb,
  output logic        wb_en_wb,
  output logic        misalign,
  output logic        bus_err,
  output logic        state_dbg
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  // Handshake: dm_req stays high from ACCESS entry until the cycle dm_ready is
  // seen (transfer done) or the wait budget expires; request fields are
  // registered at entry so they cannot move while dm_req is high.
  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        in_access, is_mem, op_ok, start, bad, done, timeout;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;
  logic [4:0]  ld_rd_q;
  logic        ld_wen_q, dm_we_q;
  logic [29:0] dm_word_q;
  logic [31:0] dm_wdata_q, wb_data_q, st_wdata, ld_data;
  logic [3:0]  dm_wstrb_q, st_strb;
  logic [4:0]  rd_addr_wb_q;
  logic        wb_en_wb_q, misalign_q, bus_err_q;

  assign in_access = (state_q == ST_ACCESS);
  assign is_mem    = mem_rd | mem_wr;
  assign op_ok     = f3_legal(funct3, mem_wr) & f3_aligned(funct3, alu_out[1:0]);
  assign start     = (state_q == ST_IDLE) & in_valid & is_mem & op_ok;
  assign bad       = (state_q == ST_IDLE) & in_valid & is_mem & ~op_ok;
  assign done      = in_access & dm_ready;
  assign timeout   = in_access & ~dm_ready & (cnt_q == CW'(WAIT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
        end
      end
      ST_ACCESS: begin
        if (dm_ready || timeout) state_d = ST_IDLE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  load_store_align u_align (
    .st_funct3_i (funct3),
    .st_off_i    (alu_out[1:0]),
    .st_data_i   (src2_st1),
    .st_strb_o   (st_strb),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (ld_f3_q),
    .ld_off_i    (ld_off_q),
    .ld_rdata_i  (dm_rdata),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_f3_q      <= '0;
      ld_off_q     <= '0;
      ld_rd_q      <= '0;
      ld_wen_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_word_q    <= '0;
      dm_wdata_q   <= '0;
      dm_wstrb_q   <= '0;
      wb_data_q    <= '0;
      rd_addr_wb_q <= '0;
      wb_en_wb_q   <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      wb_en_wb_q <= 1'b0;
      if (!in_access) begin
        if (in_valid && !is_mem) begin
          wb_data_q    <= alu_out;
          rd_addr_wb_q <= rd_addr_mem;
          wb_en_wb_q   <= wb_en_mem;
        end else if (bad) begin
          misalign_q <= 1'b1;
        end else if (start) begin
          ld_f3_q    <= funct3;
          ld_off_q   <= alu_out[1:0];
          ld_rd_q    <= rd_addr_mem;
          ld_wen_q   <= wb_en_mem & ~mem_wr;
          dm_we_q    <= mem_wr;
          dm_word_q  <= alu_out[31:2];
          dm_wdata_q <= st_wdata;
          dm_wstrb_q <= mem_wr ? st_strb : 4'b0000;
        end
      end else if (done) begin
        if (!dm_we_q) wb_data_q <= ld_data;
        rd_addr_wb_q <= ld_rd_q;
        wb_en_wb_q   <= ld_wen_q;
      end else if (timeout) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign stall      = start | (in_access & ~dm_ready & ~timeout);
  assign dm_req     = in_access;
  assign dm_we      = in_access & dm_we_q;
  assign dm_addr    = {dm_word_q, 2'b00};
  assign dm_wdata   = dm_wdata_q;
  assign dm_wstrb   = dm_wstrb_q;
  assign wb_data    = wb_data_q;
  assign rd_addr_wb = rd_addr_wb_q;
  assign wb_en_wb   = wb_en_wb_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;
  assign state_dbg  = in_access;

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: a transaction-level model predicts writeback,
// misalign and bus-error events; a negedge monitor checks them in order.
module tb_mem_wb;

  localparam int WAIT_LIMIT = 16;
  localparam int W = 40;  // {wb_en, misalign, bus_err, rd[4:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mem_rd, mem_wr, wb_en_mem, dm_ready;
  logic [2:0]  funct3;
  logic [31:0] alu_out, src2_st1, dm_rdata;
  logic [4:0]  rd_addr_mem;
  logic        dm_req, dm_we, stall, wb_en_wb, misalign, bus_err, state_dbg;
  logic [31:0] dm_addr, dm_wdata, wb_data;
  logic [3:0]  dm_wstrb;
  logic [4:0]  rd_addr_wb;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mem_wb #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .funct3(funct3), .alu_out(alu_out), .src2_st1(src2_st1),
    .rd_addr_mem(rd_addr_mem), .wb_en_mem(wb_en_mem),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall),
    .wb_data(wb_data), .rd_addr_wb(rd_addr_wb), .wb_en_wb(wb_en_wb),
    .misalign(misalign), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit op_legal(input bit store, input logic [2:0] f3, input logic [31:0] addr);
    if (store && f3 > 3'd2) return 0;
    if (!store && (f3 == 3'd3 || f3 >= 3'd6)) return 0;
    return (addr % acc_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int off;
    s = '0;
    off = int'(addr % 4);
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + acc_size(f3)) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    int sz;
    sz = acc_size(f3);
    w = '0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = data[8*(b % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    longint v;
    int sz;
    sz = acc_size(f3);
    v = longint'(rdata >> (8 * (addr % 4)));
    if (sz < 4) begin
      v = v % (64'sd1 << (8 * sz));
      if (!f3[2] && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
    end
    return v[31:0];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [2:0]   fl;
    logic [W-1:0] e;
    if (!rst) begin
      fl = {wb_en_wb, misalign, bus_err};
      if (fl != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {61'd0, fl}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_flags", {61'd0, fl}, {61'd0, e[39:37]});
          if (e[39]) begin
            check("wb_rd", {59'd0, rd_addr_wb}, {59'd0, e[36:32]});
            check("wb_data", {32'd0, wb_data}, {32'd0, e[31:0]});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; wb_en_mem = 1'b0; dm_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check("idle_stall", stall, 0);
    end
  endtask

  task automatic alu_op(input logic [31:0] val, input logic [4:0] rd, input logic wen,
                        input logic rdy);
    if (wen) exp_q.push_back({3'b100, rd, val});
    @(posedge clk); #1;
    in_valid = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
    funct3 = 3'($urandom_range(0, 7)); alu_out = val; rd_addr_mem = rd; wb_en_mem = wen;
    dm_ready = rdy;
    @(negedge clk);
    check("alu_stall", stall, 0);
    check("alu_dm_req", dm_req, 0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("alu_post_stall", stall, 0);
  endtask

  task automatic mem_op(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] st, input logic [4:0] rd,
                        input logic wen, input int waits, input logic [31:0] rdata,
                        output int stalls, output logic [3:0] seen_strb,
                        output logic [31:0] seen_wdata);
    bit legal;
    legal = op_legal(wr_i, f3, addr);
    stalls = 0; seen_strb = '0; seen_wdata = '0;
    if (!legal) exp_q.push_back({3'b010, 37'd0});
    else if (waits >= WAIT_LIMIT) exp_q.push_back({3'b001, 37'd0});
    else if (!wr_i && wen) exp_q.push_back({3'b100, rd, exp_load(f3, addr, rdata)});
    @(posedge clk); #1;
    in_valid = 1'b1; mem_rd = rd_i; mem_wr = wr_i; funct3 = f3; alu_out = addr;
    src2_st1 = st; rd_addr_mem = rd; wb_en_mem = wen; dm_rdata = rdata; dm_ready = 1'b0;
    @(negedge clk);
    if (stall) stalls++;
    check("issue_dm_req", dm_req, 0);
    check("issue_stall", stall, legal);
    if (legal) begin
      for (int k = 0; k < WAIT_LIMIT; k++) begin
        @(posedge clk); #1;
        dm_ready = (k == waits);
        @(negedge clk);
        if (stall) stalls++;
        if (k == 0) begin seen_strb = dm_wstrb; seen_wdata = dm_wdata; end
        check("acc_state", state_dbg, 1);
        check("acc_dm_req", dm_req, 1);
        check("acc_dm_addr", dm_addr, addr & 32'hFFFF_FFFC);
        check("acc_dm_we", dm_we, wr_i);
        if (wr_i) begin
          check("acc_dm_wstrb", dm_wstrb, exp_strb(f3, addr));
          check("acc_dm_wdata", dm_wdata, exp_wdata(f3, st));
        end
        check("acc_stall", stall, (k != waits) && (k != WAIT_LIMIT - 1));
        if (k == waits) break;
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("post_dm_req", dm_req, 0);
    check("post_stall", stall, 0);
    check("post_state", state_dbg, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dm_req"}, dm_req, 0);
    check({tag, "_dm_we"}, dm_we, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_wb_en_wb"}, wb_en_wb, 0);
    check({tag, "_misalign"}, misalign, 0);
    check({tag, "_bus_err"}, bus_err, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_rd_addr_wb"}, rd_addr_wb, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int st;
    logic [3:0]  sstrb;
    logic [31:0] swd;
    rst = 1'b1;
    clear_inputs();
    funct3 = '0; alu_out = '0; src2_st1 = '0; rd_addr_mem = '0; dm_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_dm_addr", dm_addr, 0);
    check("reset_dm_wstrb", dm_wstrb, 0);

    // ALU result writeback, one-cycle latency
    alu_op(32'h1234_5678, 5'd5, 1'b1, 1'b0);
    check("alu_lit_data", wb_data, 32'h1234_5678);
    check("alu_lit_rd", rd_addr_wb, 5);
    check("alu_lit_wen", wb_en_wb, 1);
    // dm_ready outside ACCESS is ignored; wb_en_mem=0 gives no writeback
    alu_op(32'h0BAD_F00D, 5'd6, 1'b0, 1'b1);
    idle(2);

    // LB from byte 3 with three wait cycles
    mem_op(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd9, 1, 3, 32'h80FF_0000, st, sstrb, swd);
    check("lb_lit_stalls", st, 4);
    check("lb_lit_data", wb_data, 32'hFFFF_FF80);
    check("lb_lit_rd", rd_addr_wb, 9);

    mem_op(1, 0, 3'b001, 32'h0000_0106, 32'h0, 5'd10, 1, 0, 32'h8001_1234, st, sstrb, swd);
    check("lh_lit_stalls", st, 1);
    check("lh_lit_data", wb_data, 32'hFFFF_8001);
    mem_op(1, 0, 3'b101, 32'h0000_0102, 32'h0, 5'd11, 1, 2, 32'h8001_1234, st, sstrb, swd);
    check("lhu_lit_data", wb_data, 32'h0000_8001);
    mem_op(1, 0, 3'b100, 32'h0000_0101, 32'h0, 5'd12, 1, 0, 32'h0000_F000, st, sstrb, swd);
    check("lbu_lit_data", wb_data, 32'h0000_00F0);
    // ready on the last cycle before the wait budget runs out
    mem_op(1, 0, 3'b010, 32'h0000_0010, 32'h0, 5'd13, 1, WAIT_LIMIT - 1, 32'hDEAD_BEEF, st, sstrb, swd);
    check("lw_last_stalls", st, WAIT_LIMIT);
    check("lw_last_data", wb_data, 32'hDEAD_BEEF);
    mem_op(1, 0, 3'b000, 32'h0000_0007, 32'h0, 5'd14, 0, 1, 32'h7F00_0000, st, sstrb, swd);

    // stores
    mem_op(0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd15, 1, 1, 32'h0, st, sstrb, swd);
    check("sh_lit_strb", sstrb, 4'b1100);
    check("sh_lit_wdata", swd, 32'hABCD_ABCD);
    check("sh_lit_wen", wb_en_wb, 0);
    mem_op(0, 1, 3'b000, 32'h0000_0001, 32'h1234_565A, 5'd16, 1, 0, 32'h0, st, sstrb, swd);
    check("sb_lit_strb", sstrb, 4'b0010);
    check("sb_lit_wdata", swd, 32'h5A5A_5A5A);
    mem_op(1, 1, 3'b010, 32'h0000_0020, 32'hA5A5_0F0F, 5'd17, 1, 2, 32'h1111_1111, st, sstrb, swd);
    check("rdwr_lit_strb", sstrb, 4'b1111);
    check("rdwr_lit_wen", wb_en_wb, 0);

    // misaligned and illegal funct3
    mem_op(1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd18, 1, 0, 32'h0, st, sstrb, swd);
    check("lw_mis_lit_pulse", misalign, 1);
    check("lw_mis_lit_stalls", st, 0);
    check("lw_mis_lit_wen", wb_en_wb, 0);
    idle(1);
    check("mis_pulse_width", misalign, 0);
    mem_op(0, 1, 3'b001, 32'h0000_0103, 32'hFFFF, 5'd1, 0, 0, 32'h0, st, sstrb, swd);
    mem_op(1, 0, 3'b001, 32'h0000_0101, 32'h0, 5'd2, 1, 0, 32'h0, st, sstrb, swd);
    mem_op(1, 0, 3'b011, 32'h0000_0000, 32'h0, 5'd3, 1, 0, 32'h0, st, sstrb, swd);
    mem_op(0, 1, 3'b100, 32'h0000_0000, 32'h0, 5'd4, 0, 0, 32'h0, st, sstrb, swd);

    // timeout with dm_ready held low
    mem_op(1, 0, 3'b010, 32'h0000_0300, 32'h0, 5'd19, 1, 99, 32'h0, st, sstrb, swd);
    check("to_lit_bus_err", bus_err, 1);
    check("to_lit_stalls", st, WAIT_LIMIT);
    check("to_lit_wen", wb_en_wb, 0);
    idle(1);
    check("to_pulse_width", bus_err, 0);

    // reset in the middle of ACCESS, memory answering in the reset cycle
    @(posedge clk); #1;
    in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; alu_out = 32'h0000_0200;
    rd_addr_mem = 5'd7; wb_en_mem = 1'b1; dm_rdata = 32'h5555_AAAA; dm_ready = 1'b0;
    @(negedge clk);
    check("rst_seq_issue_stall", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_access", dm_req, 1);
    @(posedge clk); #1;
    rst = 1'b1; clear_inputs(); dm_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dm_ready = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    alu_op(32'hCAFE_0001, 5'd3, 1'b1, 1'b0);
    check("post_rst_alu_data", wb_data, 32'hCAFE_0001);
    check("post_rst_alu_wen", wb_en_wb, 1);
    idle(2);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
